seq_control: RTL
================

# seq_control

Sequencing control unit for the single-cycle CPU datapath. It decodes the 6-bit opcode and the registered zero flag into the datapath's mux selects, write enables, stack push/pop and ALU op. It adds run-control state that the datapath alone cannot provide: a PC write enable, HALT/WAIT stalls with an external event handshake, call-depth tracking with stack overflow/underflow faults, and a retired-instruction counter. It sits beside the datapath in the CPU top level; the datapath's PC register is gated by `pc_we`.

## Interface
- `DEPTH`, 8: hardware stack entries; call-depth limit.
- `WAIT_TO`, 0: WAIT timeout in cycles; 0 disables the timeout.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: current instruction bits [15:10].
- `z` in 1: registered ALU zero flag from the datapath.
- `ev` in 1: external event, level-sampled while a WAIT is pending.
- `resume` in 1: leave HALT; sampled only in HALT.
- `pc_we` out 1: PC register load enable.
- `s_inc`, `s_inm`, `we3`, `wez`, `s_pila`, `push`, `pop` out 1 each: datapath controls.
- `op_alu` out 3: ALU operation.
- `ev_ack` out 1: one-cycle pulse in the cycle a WAIT consumes `ev`.
- `halted` out 1: high in HALT state.
- `fault` out 1: sticky fault flag.
- `fault_code` out 3: 001 overflow, 010 underflow, 011 illegal, 100 wait timeout.
- `depth` out $clog2(DEPTH+1): current call depth.
- `icount` out 16: retired-instruction count, wraps modulo 2^16.

## Operation
- Decode runs in RUN only. Unlisted outputs are 0. "Advance" means `pc_we`=1, `s_inc`=1.
  - opcode[5]=1 (ALU): `op_alu`=opcode[4:2]; `we3`=1, `wez`=1; advance.
  - 0001xx (LI): `we3`=1, `s_inm`=1; advance.
  - 000000 (NOP): advance.
  - 000001 (JMP): `pc_we`=1, `s_inc`=0.
  - 000010 (JZ): `pc_we`=1, `s_inc`=!z.
  - 000011 (JNZ): `pc_we`=1, `s_inc`=z.
  - 001000 (CALL): `push`=1, `pc_we`=1, `s_inc`=0; `depth`+1.
  - 001001 (RET): `pop`=1, `s_pila`=1, `pc_we`=1; `depth`-1.
  - 001010 (HALT): `pc_we`=0; go to HALT.
  - 001011 (WAIT): if `ev`=1, `ev_ack`=1 and advance; else `pc_we`=0 and go to WAIT.
  - Any other opcode is illegal: fault code 011.
- States: RUN, WAIT, HALT, FAULT.
  - WAIT: all enables 0. `ev`=1 → `ev_ack`=1, advance, go to RUN. With `WAIT_TO`>0, the counter reaching `WAIT_TO` with `ev`=0 → FAULT, code 100.
  - HALT: all enables 0, `halted`=1. `resume`=1 → advance past HALT, go to RUN.
  - FAULT: all enables 0; exited only by reset.
- CALL at `depth`==`DEPTH` → overflow fault, code 001. RET at `depth`==0 → underflow fault, code 010.
- A faulting instruction has no effect: no push/pop, no register writes, `pc_we`=0, `depth` unchanged.
- `icount` increments in every cycle where `pc_we`=1.

## Timing
- While `reset` is low, all control outputs are forced to 0.
- Register reset values: state RUN, `depth` 0, `icount` 0, wait counter 0, `fault` 0, `fault_code` 000, `halted` 0, `ev_ack` 0.
- Control outputs are combinational (Mealy) from state, opcode, `z`, `ev` and `resume`. Zero latency: an instruction completes in its decode cycle.
- State, `depth`, `icount` and the wait counter update on the clock edge following the decode.
- The WAIT counter clears on WAIT entry and counts cycles spent in WAIT.
- `ev` and timeout in the same cycle: `ev` wins.
- `resume` asserted in the same cycle as HALT decode is ignored; HALT lasts at least one full cycle.
- `resume` outside HALT and `ev` outside a WAIT are ignored.
- Reset asserted mid-WAIT/HALT/FAULT returns to RUN with all counters cleared.
- `z` is used as presented; a flag written by an ALU op is visible to the next instruction.

## Structure
- `cpu_pkg`: opcode constants, state enum, fault-code constants.
- Sub-module `uc_decode`: purely combinational opcode/`z` → raw control-vector decode. `seq_control` gates that vector by state and fault checks.

## Test plan
- Program LI, ADD, JZ with z=1 → JZ cycle drives `s_inc`=0, `pc_we`=1; `icount`=3 after three cycles.
- CALL at `depth` 0, then RET → `push`=1 then `pop`=1 with `s_pila`=1; `depth` goes 0→1→0.
- DEPTH=2, three nested CALLs → third drives `push`=0 and `pc_we`=0; `fault`=1, `fault_code`=001; `depth` stays 2.
- WAIT with `ev` low for 5 cycles, then high → `pc_we`=0 for 5 cycles, then `ev_ack`=1 for one cycle with `pc_we`=1.
- WAIT_TO=4, `ev` held low → FAULT after 4 WAIT cycles with `fault_code`=100.
- HALT, `resume` pulsed after 3 cycles → `halted`=1 for 3 cycles, then PC advances. Reset mid-HALT → RUN with `halted`=0 and `icount`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, state and fault-code definitions for the CPU sequencing control unit.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_JMP  = 6'b000001;
    localparam logic [5:0] OP_JZ   = 6'b000010;
    localparam logic [5:0] OP_JNZ  = 6'b000011;
    localparam logic [5:0] OP_CALL = 6'b001000;
    localparam logic [5:0] OP_RET  = 6'b001001;
    localparam logic [5:0] OP_HALT = 6'b001010;
    localparam logic [5:0] OP_WAIT = 6'b001011;

    // LI occupies the whole 0001xx block; the low two bits belong to the immediate field.
    localparam logic [3:0] OP_LI_HI = 4'b0001;

    localparam logic [2:0] FC_NONE      = 3'b000;
    localparam logic [2:0] FC_OVERFLOW  = 3'b001;
    localparam logic [2:0] FC_UNDERFLOW = 3'b010;
    localparam logic [2:0] FC_ILLEGAL   = 3'b011;
    localparam logic [2:0] FC_WAIT_TO   = 3'b100;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic       s_pila;
        logic       push;
        logic       pop;
        logic [2:0] op_alu;
    } ctrl_t;

    typedef struct packed {
        logic is_call;
        logic is_ret;
        logic is_halt;
        logic is_wait;
        logic illegal;
    } op_class_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/uc_decode.sv
// Raw opcode/z decode into a datapath control vector plus instruction class flags.
module uc_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output op_class_t  cls
);

    always_comb begin
        ctrl = CTRL_IDLE;
        cls  = '0;
        if (opcode[5]) begin
            ctrl.op_alu = opcode[4:2];
            ctrl.we3    = 1'b1;
            ctrl.wez    = 1'b1;
            ctrl.pc_we  = 1'b1;
            ctrl.s_inc  = 1'b1;
        end else if (opcode[5:2] == OP_LI_HI) begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = 1'b1;
            ctrl.pc_we = 1'b1;
            ctrl.s_inc = 1'b1;
        end else begin
            case (opcode)
                OP_NOP: begin
                    ctrl.pc_we = 1'b1;
                    ctrl.s_inc = 1'b1;
                end
                OP_JMP: ctrl.pc_we = 1'b1;
                OP_JZ: begin
                    ctrl.pc_we = 1'b1;
                    ctrl.s_inc = !z;
                end
                OP_JNZ: begin
                    ctrl.pc_we = 1'b1;
                    ctrl.s_inc = z;
                end
                OP_CALL: begin
                    ctrl.push   = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    cls.is_call = 1'b1;
                end
                OP_RET: begin
                    ctrl.pop    = 1'b1;
                    ctrl.s_pila = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    cls.is_ret  = 1'b1;
                end
                OP_HALT: cls.is_halt = 1'b1;
                // WAIT decodes as an advance; the sequencer cancels it when no event is present.
                OP_WAIT: begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.s_inc  = 1'b1;
                    cls.is_wait = 1'b1;
                end
                default: cls.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/seq_control.sv
// Run-control sequencer: gates the raw decode by RUN/WAIT/HALT/FAULT state, tracks call depth,
// WAIT timeout and retired-instruction count.
module seq_control
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WAIT_TO = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [5:0]                 opcode,
    input  logic                       z,
    input  logic                       ev,
    input  logic                       resume,
    output logic                       pc_we,
    output logic                       s_inc,
    output logic                       s_inm,
    output logic                       we3,
    output logic                       wez,
    output logic                       s_pila,
    output logic                       push,
    output logic                       pop,
    output logic [2:0]                 op_alu,
    output logic                       ev_ack,
    output logic                       halted,
    output logic                       fault,
    output logic [2:0]                 fault_code,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [15:0]                icount,
    output state_t                     dbg_state
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int CW = (WAIT_TO > 1) ? $clog2(WAIT_TO) + 1 : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_TO > 0) ? WAIT_TO - 1 : 0);

    state_t        state;
    state_t        next_state;
    ctrl_t         ctrl_raw;
    ctrl_t         ctrl;
    op_class_t     cls;
    logic          ack;
    logic          fault_set;
    logic [2:0]    fault_code_nx;
    logic [CW-1:0] wait_cnt;

    uc_decode u_decode (
        .opcode (opcode),
        .z      (z),
        .ctrl   (ctrl_raw),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        fault_set     = 1'b0;
        fault_code_nx = FC_NONE;
        case (state)
            ST_RUN: begin
                if (cls.illegal) begin
                    fault_set     = 1'b1;
                    fault_code_nx = FC_ILLEGAL;
                end else if (cls.is_call && depth == DEPTH_MAX) begin
                    fault_set     = 1'b1;
                    fault_code_nx = FC_OVERFLOW;
                end else if (cls.is_ret && depth == '0) begin
                    fault_set     = 1'b1;
                    fault_code_nx = FC_UNDERFLOW;
                end else if (cls.is_halt) begin
                    next_state = ST_HALT;
                end else if (cls.is_wait && !ev) begin
                    next_state = ST_WAIT;
                end
            end
            // An event arriving in the timeout cycle still completes the WAIT.
            ST_WAIT: begin
                if (ev) begin
                    next_state = ST_RUN;
                end else if (WAIT_TO > 0 && wait_cnt == WAIT_LAST) begin
                    fault_set     = 1'b1;
                    fault_code_nx = FC_WAIT_TO;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_FAULT;
        endcase
        if (fault_set) begin
            next_state = ST_FAULT;
        end
    end

    // ev/ev_ack handshake: ev is a level held by the requester; ev_ack pulses for exactly the
    // cycle in which a WAIT (decoded in RUN or pending in WAIT) observes ev=1 and retires.
    always_comb begin
        ctrl = CTRL_IDLE;
        ack  = 1'b0;
        if (reset) begin
            case (state)
                ST_RUN: begin
                    if (!fault_set && !cls.is_halt && !(cls.is_wait && !ev)) begin
                        ctrl = ctrl_raw;
                        ack  = cls.is_wait;
                    end
                end
                ST_WAIT: begin
                    if (ev) begin
                        ctrl.pc_we = 1'b1;
                        ctrl.s_inc = 1'b1;
                        ack        = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        ctrl.pc_we = 1'b1;
                        ctrl.s_inc = 1'b1;
                    end
                end
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth      <= '0;
            icount     <= '0;
            wait_cnt   <= '0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            if (ctrl.pc_we) begin
                icount <= icount + 16'd1;
            end
            if (ctrl.push) begin
                depth <= depth + 1'b1;
            end else if (ctrl.pop) begin
                depth <= depth - 1'b1;
            end
            // Held at zero outside WAIT so every WAIT entry starts counting from zero.
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (fault_set) begin
                fault      <= 1'b1;
                fault_code <= fault_code_nx;
            end
        end
    end

    assign pc_we     = ctrl.pc_we;
    assign s_inc     = ctrl.s_inc;
    assign s_inm     = ctrl.s_inm;
    assign we3       = ctrl.we3;
    assign wez       = ctrl.wez;
    assign s_pila    = ctrl.s_pila;
    assign push      = ctrl.push;
    assign pop       = ctrl.pop;
    assign op_alu    = ctrl.op_alu;
    assign ev_ack    = ack;
    assign halted    = (state == ST_HALT);
    assign dbg_state = state;

endmodule
